// File: rtl/lane_skid_array.sv
// Splits a flattened bus into independent lanes, each with a 2-entry skid buffer
// and a wrapping count of completed output transfers, then re-merges the lanes.
module lane_skid_array #(
    parameter int NUM_LANES  = 2,
    parameter int LANE_WIDTH = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_flush,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] i_data_in,
    input  logic [NUM_LANES-1:0]            i_valid,
    output logic [NUM_LANES-1:0]            o_ready,
    output logic [NUM_LANES*LANE_WIDTH-1:0] o_data_out,
    output logic [NUM_LANES-1:0]            o_valid,
    input  logic [NUM_LANES-1:0]            i_ready,
    output logic [NUM_LANES*CNT_WIDTH-1:0]  o_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } lane_state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        lane_state_e           state_q, state_d;
        logic [LANE_WIDTH-1:0] head_q, head_d;
        logic [LANE_WIDTH-1:0] skid_q, skid_d;
        logic [LANE_WIDTH-1:0] lane_in;
        logic [CNT_WIDTH-1:0]  count_q, count_d;
        logic                  push, pop;

        assign lane_in = i_data_in[k*LANE_WIDTH +: LANE_WIDTH];

        // Handshake outputs decode only the state register, never the inputs.
        assign o_valid[k] = (state_q != EMPTY);
        assign o_ready[k] = (state_q != FULL);
        assign o_data_out[k*LANE_WIDTH +: LANE_WIDTH] = head_q;
        assign o_count[k*CNT_WIDTH +: CNT_WIDTH]      = count_q;

        assign push = i_valid[k] & (state_q != FULL);
        assign pop  = i_ready[k] & (state_q != EMPTY);

        always_comb begin
            state_d = state_q;
            head_d  = head_q;
            skid_d  = skid_q;
            count_d = count_q;
            if (i_flush) begin
                state_d = EMPTY;
                count_d = '0;
            end else begin
                if (pop) begin
                    count_d = count_q + CNT_ONE;
                end
                case (state_q)
                    EMPTY: begin
                        if (push) begin
                            state_d = ONE;
                            head_d  = lane_in;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            head_d = lane_in;
                        end else if (push) begin
                            state_d = FULL;
                            skid_d  = lane_in;
                        end else if (pop) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        // Ready is low here, so a pop is the only possible event.
                        if (pop) begin
                            state_d = ONE;
                            head_d  = skid_q;
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= EMPTY;
                head_q  <= '0;
                skid_q  <= '0;
                count_q <= '0;
            end else begin
                state_q <= state_d;
                head_q  <= head_d;
                skid_q  <= skid_d;
                count_q <= count_d;
            end
        end
    end

endmodule

// File: tb/tb_lane_skid_array.sv
// Randomised and directed bench for lane_skid_array, compared against a
// queue-based model of two independent depth-2 FIFO lanes with wrapping counters.
module tb_lane_skid_array;

    localparam int NL = 2;
    localparam int LW = 8;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_flush = 1'b0;
    logic [NL*LW-1:0]  i_data_in = '0;
    logic [NL-1:0]     i_valid = '0;
    logic [NL-1:0]     o_ready;
    logic [NL*LW-1:0]  o_data_out;
    logic [NL-1:0]     o_valid;
    logic [NL-1:0]     i_ready = '0;
    logic [NL*CW-1:0]  o_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    int         mcnt0 = 0;
    int         mcnt1 = 0;

    lane_skid_array #(
        .NUM_LANES (NL),
        .LANE_WIDTH(LW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (i_flush),
        .i_data_in (i_data_in),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_data_out(o_data_out),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_count   (o_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic compareModel();
        logic [1:0]  exp_valid;
        logic [1:0]  exp_ready;
        logic [3:0]  exp_count;
        logic [15:0] exp_data;
        logic [15:0] mask;
        exp_valid = '0;
        exp_data  = '0;
        mask      = '0;
        exp_ready = {mq1.size() < 2, mq0.size() < 2};
        if (mq0.size() > 0) begin
            exp_valid[0]   = 1'b1;
            exp_data[7:0]  = mq0[0];
            mask[7:0]      = 8'hFF;
        end
        if (mq1.size() > 0) begin
            exp_valid[1]   = 1'b1;
            exp_data[15:8] = mq1[0];
            mask[15:8]     = 8'hFF;
        end
        exp_count = {2'(mcnt1), 2'(mcnt0)};
        checkOutput("valid", 32'(o_valid), 32'(exp_valid));
        checkOutput("ready", 32'(o_ready), 32'(exp_ready));
        checkOutput("count", 32'(o_count), 32'(exp_count));
        checkOutput("data", 32'(o_data_out & mask), 32'(exp_data));
    endtask

    // Advances the model with the inputs that were present at the rising edge.
    task automatic modelStep();
        logic push0, pop0, push1, pop1;
        push0 = i_valid[0] && (mq0.size() < 2);
        pop0  = i_ready[0] && (mq0.size() > 0);
        push1 = i_valid[1] && (mq1.size() < 2);
        pop1  = i_ready[1] && (mq1.size() > 0);
        if (i_flush) begin
            mq0.delete();
            mq1.delete();
            mcnt0 = 0;
            mcnt1 = 0;
        end else begin
            if (pop0) begin
                void'(mq0.pop_front());
                mcnt0 = (mcnt0 + 1) % 4;
            end
            if (pop1) begin
                void'(mq1.pop_front());
                mcnt1 = (mcnt1 + 1) % 4;
            end
            if (push0) mq0.push_back(i_data_in[7:0]);
            if (push1) mq1.push_back(i_data_in[15:8]);
        end
    endtask

    task automatic applyStimulus(input logic flush, input logic [1:0] valid,
                                 input logic [1:0] ready, input logic [15:0] data);
        @(negedge clk);
        i_flush   = flush;
        i_valid   = valid;
        i_ready   = ready;
        i_data_in = data;
        compareModel();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 32'(o_valid), 32'h0);
        checkOutput({tag, "_ready"}, 32'(o_ready), 32'h3);
        checkOutput({tag, "_count"}, 32'(o_count), 32'h0);
        checkOutput({tag, "_data"}, 32'(o_data_out), 32'h0);
    endtask

    initial begin
        $display("[TB] start");
        #12;
        checkResetState("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming on lane 0.
        applyStimulus(1'b0, 2'b01, 2'b01, 16'h0011);
        checkOutput("stream_h1", 32'(o_data_out[7:0]), 32'h11);
        applyStimulus(1'b0, 2'b01, 2'b01, 16'h0022);
        checkOutput("stream_h2", 32'(o_data_out[7:0]), 32'h22);
        applyStimulus(1'b0, 2'b01, 2'b01, 16'h0033);
        checkOutput("stream_h3", 32'(o_data_out[7:0]), 32'h33);
        checkOutput("stream_rdy", 32'(o_ready[0]), 32'h1);
        applyStimulus(1'b0, 2'b00, 2'b01, 16'h0000);
        checkOutput("stream_cnt", 32'(o_count[1:0]), 32'h3);

        // Backpressure on lane 1.
        applyStimulus(1'b0, 2'b10, 2'b00, 16'hA000);
        applyStimulus(1'b0, 2'b10, 2'b00, 16'hB100);
        checkOutput("bp_full", 32'(o_ready[1]), 32'h0);
        applyStimulus(1'b0, 2'b10, 2'b00, 16'hC200);
        checkOutput("bp_hold", 32'(o_data_out[15:8]), 32'hA0);
        applyStimulus(1'b0, 2'b10, 2'b10, 16'hC200);
        checkOutput("bp_h2", 32'(o_data_out[15:8]), 32'hB1);
        applyStimulus(1'b0, 2'b10, 2'b10, 16'hC200);
        checkOutput("bp_h3", 32'(o_data_out[15:8]), 32'hC2);
        applyStimulus(1'b0, 2'b00, 2'b10, 16'h0000);

        // Lane 0 stalled full while lane 1 streams.
        applyStimulus(1'b0, 2'b01, 2'b00, 16'h0066);
        applyStimulus(1'b0, 2'b01, 2'b00, 16'h0077);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 2'b11, 2'b10, {8'(i), 8'hEE});
            checkOutput("indep_h0", 32'(o_data_out[7:0]), 32'h66);
        end
        applyStimulus(1'b0, 2'b00, 2'b11, 16'h0000);
        applyStimulus(1'b0, 2'b00, 2'b11, 16'h0000);

        // Simultaneous push and pop while holding one entry.
        applyStimulus(1'b0, 2'b01, 2'b00, 16'h0044);
        applyStimulus(1'b0, 2'b01, 2'b01, 16'h0055);
        checkOutput("pp_head", 32'(o_data_out[7:0]), 32'h55);
        checkOutput("pp_rdy", 32'(o_ready[0]), 32'h1);

        // Counter wrap after a flush.
        applyStimulus(1'b1, 2'b00, 2'b00, 16'h0000);
        applyStimulus(1'b0, 2'b01, 2'b01, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, (i < 4) ? 2'b01 : 2'b00, 2'b01, 16'(i + 2));
            checkOutput("wrap_cnt", 32'(o_count[1:0]), 32'((i + 1) % 4));
        end

        // Flush with one buffered entry and a concurrent push.
        applyStimulus(1'b0, 2'b01, 2'b00, 16'h0099);
        applyStimulus(1'b1, 2'b01, 2'b01, 16'h00AA);
        checkOutput("fl_valid", 32'(o_valid[0]), 32'h0);
        checkOutput("fl_count", 32'(o_count[1:0]), 32'h0);
        checkOutput("fl_ready", 32'(o_ready[0]), 32'h1);

        // Asynchronous reset in the middle of traffic.
        applyStimulus(1'b0, 2'b11, 2'b00, 16'h1234);
        applyStimulus(1'b0, 2'b11, 2'b01, 16'h5678);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("async");
        mq0.delete();
        mq1.delete();
        mcnt0 = 0;
        mcnt1 = 0;
        i_valid = '0;
        i_ready = '0;
        i_flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 2'($urandom), 2'($urandom), 16'($urandom));
        end
        @(negedge clk);
        compareModel();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
